// File: rtl/uart_pkg.sv
// Shared definitions for the UART memory-dump slice: FSM encoding,
// 8N1 frame constants and a baud divisor helper.
// Optional feature macro: UART_MEMDUMP_CHECKSUM_EN (adds the CKSUM state).
package uart_pkg;

  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_NEXT,
    ST_FINISH
`ifdef UART_MEMDUMP_CHECKSUM_EN
    , ST_CKSUM
`endif
  } state_t;

  // Clock cycles per UART bit, rounded to nearest.
  function automatic int unsigned calc_baud_div(input int unsigned clk_hz,
                                                input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. ready is also high in the final cycle of the stop
// bit so a byte loaded then starts the next frame with no idle gap.
module uart_tx_byte #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       TX,
  output logic       ready
);
  import uart_pkg::*;

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);

  logic [CNT_W-1:0] baud_q;
  logic [3:0]       bit_q;
  logic [8:0]       shift_q;
  logic             active_q;
  logic             bit_end;
  logic             frame_end;

  assign bit_end   = (baud_q == CNT_W'(BAUD_DIV - 1));
  assign frame_end = active_q && bit_end && (bit_q == 4'(FRAME_BITS - 1));
  assign ready     = !active_q || frame_end;

  // Baud/bit counters and line driver; shift_q carries data then the stop bit.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      TX       <= STOP_BIT;
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else if (load && ready) begin
      TX       <= START_BIT;
      active_q <= 1'b1;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= {STOP_BIT, byte_in};
    end else if (active_q) begin
      if (bit_end) begin
        baud_q <= '0;
        if (bit_q == 4'(FRAME_BITS - 1)) begin
          active_q <= 1'b0;
          bit_q    <= '0;
          TX       <= STOP_BIT;
        end else begin
          bit_q   <= bit_q + 4'd1;
          TX      <= shift_q[0];
          shift_q <= {STOP_BIT, shift_q[8:1]};
        end
      end else begin
        baud_q <= baud_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_memdump.sv
// Dumps an inclusive, wrapping word-address range of a synchronous-read
// memory over UART, one 8N1 frame per byte.
// Optional feature macro: UART_MEMDUMP_CHECKSUM_EN (trailing mod-256 sum frame).
module uart_memdump #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BAUD_DIV  = 434,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              TX,
  output logic              busy,
  output logic              done
);
  import uart_pkg::*;

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(NBYTES - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   end_q;
  logic [DATA_W-1:0]   word_q;
  logic [BIDX_W-1:0]   byte_idx_q;
  logic                tx_load;
  logic [7:0]          tx_byte;
  logic                tx_ready;
`ifdef UART_MEMDUMP_CHECKSUM_EN
  logic [7:0]          cksum_q;
`endif

  function automatic logic [7:0] pick(input logic [DATA_W-1:0] w,
                                      input int unsigned idx);
    int unsigned k;
    k = (MSB_FIRST != 0) ? (NBYTES - 1 - idx) : idx;
    return 8'(w >> (k * 8));
  endfunction

  assign busy = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done = (state_q == ST_FINISH);

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .CLK     (CLK),
    .rst     (rst),
    .load    (tx_load),
    .byte_in (tx_byte),
    .TX      (TX),
    .ready   (tx_ready)
  );

  // FSM state register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and byte hand-off; the first byte comes straight from mem_data
  // in LOAD so its start bit lands in the following cycle.
  always_comb begin
    state_d = state_q;
    tx_load = 1'b0;
    tx_byte = '0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        tx_load = 1'b1;
        tx_byte = pick(mem_data, 0);
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (byte_idx_q != LAST_IDX) begin
            tx_load = 1'b1;
            tx_byte = pick(word_q, 32'(byte_idx_q) + 1);
          end else if (mem_addr != end_q) begin
            state_d = ST_NEXT;
          end else begin
`ifdef UART_MEMDUMP_CHECKSUM_EN
            tx_load = 1'b1;
            tx_byte = cksum_q;
            state_d = ST_CKSUM;
`else
            state_d = ST_FINISH;
`endif
          end
        end
      end
      ST_NEXT: state_d = ST_FETCH;
`ifdef UART_MEMDUMP_CHECKSUM_EN
      ST_CKSUM: if (tx_ready) state_d = ST_FINISH;
`endif
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Address range, word register and byte index.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      mem_addr   <= '0;
      end_q      <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          mem_addr <= start_addr;
          end_q    <= end_addr;
        end
        ST_LOAD: begin
          word_q     <= mem_data;
          byte_idx_q <= '0;
        end
        ST_SEND: if (tx_ready && byte_idx_q != LAST_IDX) byte_idx_q <= byte_idx_q + BIDX_W'(1);
        ST_NEXT: mem_addr <= mem_addr + ADDR_W'(1);
        default: ;
      endcase
    end
  end

`ifdef UART_MEMDUMP_CHECKSUM_EN
  // Running sum of every data byte handed to the transmitter.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst)                          cksum_q <= '0;
    else if (state_q == ST_IDLE && start) cksum_q <= '0;
    else if (tx_load)                 cksum_q <= cksum_q + tx_byte;
  end
`endif

endmodule

// File: tb/tb_uart_memdump.sv
// Scoreboard bench: stimulus pushes expected frames, per-DUT monitors decode TX.
module tb_uart_memdump;

  localparam int BD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [3:0]  sa = '0, ea = '0;
  logic [3:0]  ma0, ma1;
  logic [31:0] md0, md1;
  logic        tx0, tx1, busy0, busy1, done0, done1;
  logic [31:0] mem [16];

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int last_end [2];
  int first_sc [2];

  typedef struct {
    logic [7:0] b;
    int         gap;
    logic [3:0] addr;
  } exp_t;
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  uart_memdump #(.ADDR_W(4), .DATA_W(32), .BAUD_DIV(BD), .MSB_FIRST(0)) dut0 (
    .CLK(clk), .rst(rst), .start(start0), .start_addr(sa), .end_addr(ea),
    .mem_addr(ma0), .mem_data(md0), .TX(tx0), .busy(busy0), .done(done0));

  uart_memdump #(.ADDR_W(4), .DATA_W(32), .BAUD_DIV(BD), .MSB_FIRST(1)) dut1 (
    .CLK(clk), .rst(rst), .start(start1), .start_addr(sa), .end_addr(ea),
    .mem_addr(ma1), .mem_data(md1), .TX(tx1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    md0 <= mem[ma0];
    md1 <= mem[ma1];
  end

  function automatic logic tx_of(input int i);   return (i == 0) ? tx0 : tx1;     endfunction
  function automatic logic busy_of(input int i); return (i == 0) ? busy0 : busy1; endfunction
  function automatic logic done_of(input int i); return (i == 0) ? done0 : done1; endfunction
  function automatic logic [3:0] addr_of(input int i); return (i == 0) ? ma0 : ma1; endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input int gap, input logic [3:0] a);
    exp_t e;
    e.b = b; e.gap = gap; e.addr = a;
    if (i == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Expected frames for one memory word; gap 3 = NEXT, FETCH, LOAD between words.
  task automatic push_word(input int i, input logic [3:0] a, input bit first, input bit msb);
    logic [31:0] w;
    w = mem[a];
    for (int j = 0; j < 4; j++)
      push(i, msb ? w[(3-j)*8 +: 8] : w[j*8 +: 8], (j == 0) ? (first ? -1 : 3) : 0, a);
  endtask

  task automatic run_monitor(input int i);
    logic v;
    logic [7:0] data;
    bit ok, aborted;
    int sc, bp, prev_end;
    logic [3:0] a;
    exp_t e;
    prev_end = 0;
    forever begin
      @(negedge clk);
      if (!rst && tx_of(i) === 1'b0) begin
        sc = cyc; a = addr_of(i); ok = 1; aborted = 0; data = '0;
        for (int k = 0; k < 10*BD; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin aborted = 1; break; end
          v  = tx_of(i);
          bp = k / BD;
          if (bp == 0)           begin if (v !== 1'b0) ok = 0; end
          else if (bp == 9)      begin if (v !== 1'b1) ok = 0; end
          else if (k % BD == 0)  data[bp-1] = v;
          else if (v !== data[bp-1]) ok = 0;
        end
        if (!aborted) begin
          if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
            checks++; fails++;
            $display("FAIL unexpected_frame dut%0d: got byte 0x%0h, required no frame", i, data);
          end else begin
            if (i == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check("frame_byte", data, e.b);
            check("frame_shape", ok, 1);
            check("frame_addr", a, e.addr);
            if (e.gap >= 0) check("frame_gap", sc - prev_end - 1, e.gap);
            else            first_sc[i] = sc;
          end
          prev_end = cyc;
          last_end[i] = cyc;
        end
      end
    end
  endtask

  task automatic run_done_monitor(input int i);
    forever begin
      @(negedge clk);
      if (done_of(i) === 1'b1) begin
        check("busy_at_done", busy_of(i), 0);
        check("done_after_stop", cyc - last_end[i], 1);
      end
    end
  endtask

  initial run_monitor(0);
  initial run_monitor(1);
  initial run_done_monitor(0);
  initial run_done_monitor(1);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic pulse_start(input int i);
    @(negedge clk);
    if (i == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    check("busy_after_start", busy_of(i), 1);
  endtask

  task automatic wait_done(input int i, input int budget, input bit poke, output int dc);
    bit seen;
    seen = 0; dc = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done_of(i) === 1'b1) begin seen = 1; dc = cyc; break; end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      if (poke) begin
        if (i == 0) start0 = 1'b1; else start1 = 1'b1;
      end
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      check("done_one_cycle", done_of(i), 0);
    end
  endtask

  initial begin
    int dc, cnt;
    bit seen;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0F1E2D3C + i * 32'h11111111;
    mem[3] = 32'hA1B2C3D4;

    repeat (3) @(negedge clk);
    check("rst_tx0", tx0, 1);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_addr0", ma0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_tx1", tx1, 1);
    check("idle_busy1", busy1, 0);
    check("idle_done1", done1, 0);
    check("idle_addr1", ma1, 0);

    // Single word, LSB byte first.
    sa = 4'd3; ea = 4'd3;
    push(0, 8'hD4, -1, 4'd3); push(0, 8'hC3, 0, 4'd3);
    push(0, 8'hB2, 0, 4'd3);  push(0, 8'hA1, 0, 4'd3);
    pulse_start(0);
    wait_done(0, 400, 0, dc);
    check("done_latency", dc - first_sc[0], 160);

    // Single word, top byte first.
    push(1, 8'hA1, -1, 4'd3); push(1, 8'hB2, 0, 4'd3);
    push(1, 8'hC3, 0, 4'd3);  push(1, 8'hD4, 0, 4'd3);
    pulse_start(1);
    wait_done(1, 400, 0, dc);
    check("done_latency_msb", dc - first_sc[1], 160);

    // Wrapping range 14,15,0,1.
    sa = 4'd14; ea = 4'd1;
    push_word(0, 4'd14, 1, 0); push_word(0, 4'd15, 0, 0);
    push_word(0, 4'd0, 0, 0);  push_word(0, 4'd1, 0, 0);
    pulse_start(0);
    wait_done(0, 800, 0, dc);

    // Restart mid-dump ignored; start in done cycle ignored.
    sa = 4'd5; ea = 4'd6;
    push_word(0, 4'd5, 1, 0); push_word(0, 4'd6, 0, 0);
    pulse_start(0);
    repeat (50) @(negedge clk);
    sa = 4'd9; ea = 4'd10;
    pulse_start(0);
    wait_done(0, 400, 1, dc);
    cnt = 0;
    repeat (10) begin @(negedge clk); if (busy0 !== 1'b0) cnt++; end
    check("start_in_done_ignored", cnt, 0);

    // Two words 0..1 (checksum frame when enabled).
    mem[0] = 32'h000000FF; mem[1] = 32'h00000002;
    sa = 4'd0; ea = 4'd1;
    push(0, 8'hFF, -1, 4'd0); push(0, 8'h00, 0, 4'd0); push(0, 8'h00, 0, 4'd0); push(0, 8'h00, 0, 4'd0);
    push(0, 8'h02, 3, 4'd1);  push(0, 8'h00, 0, 4'd1); push(0, 8'h00, 0, 4'd1); push(0, 8'h00, 0, 4'd1);
`ifdef UART_MEMDUMP_CHECKSUM_EN
    push(0, 8'h01, 0, 4'd1);
`endif
    pulse_start(0);
    wait_done(0, 500, 0, dc);

    // Reset during data bit 3 of the second frame.
    sa = 4'd3; ea = 4'd3;
    push_word(0, 4'd3, 1, 0);
    pulse_start(0);
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      if (tx0 === 1'b0) begin seen = 1; break; end
      @(negedge clk);
    end
    check("first_start_bit_seen", seen, 1);
    repeat (57) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_tx", tx0, 1);
    check("midrst_busy", busy0, 0);
    check("midrst_done", done0, 0);
    check("midrst_addr", ma0, 0);
    exp_q0.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (60) begin @(negedge clk); if (tx0 !== 1'b1 || done0 !== 1'b0) cnt++; end
    check("quiet_after_rst", cnt, 0);
    push_word(0, 4'd3, 1, 0);
    pulse_start(0);
    wait_done(0, 400, 0, dc);

    repeat (5) @(negedge clk);
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
